// File: rtl/leitor_amostras_pwm.sv
// Fetches one sample per PWM period from external memory, double-buffers it and drives PWM audio.
// Emits a one-cycle count strobe per consumed sample; underrun when a boundary finds nothing ready.
module leitor_amostras_pwm #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic [ADDR_W-1:0] endereco,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   output logic              count,
   output logic              pwm_out,
   output logic              underrun
);

   typedef enum logic [1:0] {OCIOSO, PEDE, CHEIO} estado_t;

   localparam logic [DATA_W-1:0] CNT_MAX = '1;

   estado_t           state_reg, state_next;
   logic [DATA_W-1:0] pwm_cnt_reg, pwm_cnt_next;
   logic [DATA_W-1:0] duty_reg, duty_next;
   logic [DATA_W-1:0] buffer_reg, buffer_next;
   logic              buf_valid_reg, buf_valid_next;
   logic              mem_req_reg, mem_req_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic              count_reg, count_next;
   logic              pwm_out_reg, pwm_out_next;
   logic              underrun_reg, underrun_next;

   logic wrap;
   logic ack_valid;

   assign wrap      = play && (pwm_cnt_reg == CNT_MAX);
   // Acks that arrive with no request outstanding are ignored.
   assign ack_valid = mem_ack && mem_req_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= OCIOSO;
         pwm_cnt_reg   <= '0;
         duty_reg      <= '0;
         buffer_reg    <= '0;
         buf_valid_reg <= 1'b0;
         mem_req_reg   <= 1'b0;
         mem_addr_reg  <= '0;
         count_reg     <= 1'b0;
         pwm_out_reg   <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pwm_cnt_reg   <= pwm_cnt_next;
         duty_reg      <= duty_next;
         buffer_reg    <= buffer_next;
         buf_valid_reg <= buf_valid_next;
         mem_req_reg   <= mem_req_next;
         mem_addr_reg  <= mem_addr_next;
         count_reg     <= count_next;
         pwm_out_reg   <= pwm_out_next;
         underrun_reg  <= underrun_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      duty_next      = duty_reg;
      buffer_next    = buffer_reg;
      buf_valid_next = buf_valid_reg;
      mem_req_next   = mem_req_reg;
      mem_addr_next  = mem_addr_reg;
      count_next     = 1'b0;
      underrun_next  = 1'b0;
      pwm_cnt_next   = play ? pwm_cnt_reg + 1'b1 : '0;
      pwm_out_next   = play && (pwm_cnt_reg < duty_reg);

      // Sample boundary: buffered sample first, then a same-cycle ack bypass, else repeat old duty.
      if (wrap) begin
         if (buf_valid_reg) begin
            duty_next      = buffer_reg;
            buf_valid_next = 1'b0;
            count_next     = 1'b1;
         end else if (ack_valid) begin
            duty_next  = mem_data;
            count_next = 1'b1;
         end else begin
            underrun_next = 1'b1;
         end
      end

      case (state_reg)
         OCIOSO: begin
            // Waiting one cycle after count lets the address source settle on the next address.
            if (play && !buf_valid_reg && !count_reg) begin
               mem_addr_next = endereco;
               mem_req_next  = 1'b1;
               state_next    = PEDE;
            end
         end
         PEDE: begin
            if (ack_valid) begin
               mem_req_next = 1'b0;
               if (wrap) begin
                  state_next = OCIOSO;
               end else begin
                  buffer_next    = mem_data;
                  buf_valid_next = 1'b1;
                  state_next     = CHEIO;
               end
            end
         end
         CHEIO: begin
            if (wrap) begin
               state_next = OCIOSO;
            end
         end
         default: begin
            state_next = OCIOSO;
         end
      endcase
   end

   assign mem_req  = mem_req_reg;
   assign mem_addr = mem_addr_reg;
   assign count    = count_reg;
   assign pwm_out  = pwm_out_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_leitor_amostras_pwm.sv
// Bench for leitor_amostras_pwm with 4-bit samples (16-cycle PWM period), memory and address models.
module tb_leitor_amostras_pwm;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 4;
   localparam int PER    = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              play;
   logic [ADDR_W-1:0] endereco;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
   logic              count;
   logic              pwm_out;
   logic              underrun;

   always #5 clk = ~clk;

   leitor_amostras_pwm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .play     (play),
      .endereco (endereco),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .count    (count),
      .pwm_out  (pwm_out),
      .underrun (underrun)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [DATA_W-1:0] mem_img [0:63];
   logic [DATA_W-1:0] samp_q [$];
   logic [ADDR_W-1:0] addr_q [$];
   logic              auto_ack   = 1'b0;
   logic              addr_model = 1'b0;
   logic              prev_req   = 1'b0;
   int                ack_lat    = 2;
   int                wait_cnt   = 0;
   int                n_count    = 0;
   int                n_under    = 0;

   // One clock: observe at the falling edge, run memory/address models, scoreboard new requests.
   task automatic cyc();
      logic [ADDR_W-1:0] exp_a;
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      if (count === 1'b1) n_count++;
      if (underrun === 1'b1) n_under++;
      compared++;
      if ((count & underrun) !== 1'b0) begin
         mismatched++;
         $display("FAIL strobe_excl: count=%b underrun=%b, required not both 1", count, underrun);
      end
      if (mem_req === 1'b1 && !prev_req) begin
         compared++;
         if (addr_q.size() == 0) begin
            mismatched++;
            $display("FAIL req_addr: request at %0d, required no request", mem_addr);
         end else begin
            exp_a = addr_q.pop_front();
            if (mem_addr !== exp_a) begin
               mismatched++;
               $display("FAIL req_addr: mem_addr=%0d required %0d", mem_addr, exp_a);
            end
         end
      end
      prev_req = (mem_req === 1'b1);
      if (count === 1'b1 && addr_model) begin
         endereco = endereco + 1'b1;
         addr_q.push_back(endereco);
      end
      if (auto_ack && mem_req === 1'b1) begin
         if (wait_cnt >= ack_lat) begin
            mem_ack  = 1'b1;
            mem_data = mem_img[mem_addr[5:0]];
            samp_q.push_back(mem_img[mem_addr[5:0]]);
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   task automatic apply_reset(input logic [ADDR_W-1:0] a);
      reset      = 1'b1;
      play       = 1'b0;
      mem_ack    = 1'b0;
      auto_ack   = 1'b0;
      addr_model = 1'b0;
      repeat (2) cyc();
      samp_q.delete();
      addr_q.delete();
      endereco = a;
      addr_q.push_back(a);
      wait_cnt = 0;
      n_count  = 0;
      n_under  = 0;
      reset    = 1'b0;
   endtask

   task automatic wait_count(input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         cyc();
         if (count === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic pop_sample(output int exp, output bit ok);
      ok  = (samp_q.size() != 0);
      exp = 0;
      if (ok) exp = int'(samp_q.pop_front());
   endtask

   // Runs the 16 cycles following a count; optional manual ack injected after cycle inj_k.
   task automatic run_period(input int exp_duty, input int inj_k, input logic [DATA_W-1:0] inj_d,
                             output int high, output int ptn_err, output int strobe_k);
      high = 0; ptn_err = 0; strobe_k = -1;
      for (int k = 1; k <= PER; k++) begin
         cyc();
         if (pwm_out === 1'b1) high++;
         if (pwm_out !== ((k - 1) < exp_duty)) ptn_err++;
         if ((count === 1'b1 || underrun === 1'b1) && strobe_k < 0) strobe_k = k;
         if (k == inj_k) begin
            mem_ack  = 1'b1;
            mem_data = inj_d;
            samp_q.push_back(inj_d);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; play = 1'b1; endereco = ADDR_W'(5); mem_ack = 1'b0; mem_data = '0;
      repeat (3) cyc();
      compared++;
      if ({mem_req, count, pwm_out, underrun} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_outs: req/count/pwm/under=%b required 0000", {mem_req, count, pwm_out, underrun});
      end
      compared++;
      if (mem_addr !== '0) begin
         mismatched++;
         $display("FAIL reset_addr: mem_addr=%0d required 0", mem_addr);
      end
      addr_q.delete();
      addr_q.push_back(ADDR_W'(5));
      reset = 1'b0;
      cyc(); cyc();
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(5)) begin
         mismatched++;
         $display("FAIL release_req: mem_req=%b mem_addr=%0d required 1 and 5", mem_req, mem_addr);
      end
      reset = 1'b1;
      cyc();
      compared++;
      if (mem_req !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_pede: mem_req=%b required 0", mem_req);
      end
      reset = 1'b0; play = 1'b0; mem_ack = 1'b1; mem_data = 4'hA;
      repeat (3) cyc();
      addr_q.push_back(ADDR_W'(5));
      play = 1'b1;
      cyc();
      compared++;
      if (mem_req !== 1'b1) begin
         mismatched++;
         $display("FAIL late_ack_ignored: mem_req=%b required 1", mem_req);
      end
   endtask

   task automatic test_steady();
      int n, exp, high, perr, sk;
      bit ok;
      apply_reset(ADDR_W'(5));
      play = 1'b1; auto_ack = 1'b1; ack_lat = 2; addr_model = 1'b1;
      wait_count(40, n);
      compared++;
      if (n != PER) begin
         mismatched++;
         $display("FAIL first_count: count after %0d cycles required %0d", n, PER);
      end
      for (int p = 0; p < 4; p++) begin
         pop_sample(exp, ok);
         compared++;
         if (!ok) begin
            mismatched++;
            $display("FAIL steady_sample: count with no sample fetched, required a fetched sample");
         end
         run_period(exp, 0, '0, high, perr, sk);
         compared++;
         if (high != exp || perr != 0) begin
            mismatched++;
            $display("FAIL steady_pwm: high=%0d pattern_err=%0d required high=%0d err=0", high, perr, exp);
         end
         compared++;
         if (sk != PER || count !== 1'b1) begin
            mismatched++;
            $display("FAIL steady_count: strobe at %0d count=%b required count at %0d", sk, count, PER);
         end
      end
      compared++;
      if (n_under != 0 || n_count != 5 || endereco !== ADDR_W'(10)) begin
         mismatched++;
         $display("FAIL steady_totals: under=%0d counts=%0d endereco=%0d required 0 5 10", n_under, n_count, endereco);
      end
   endtask

   task automatic test_underrun();
      int n, exp, high, perr, sk;
      bit ok;
      apply_reset(ADDR_W'(20));
      play = 1'b1; auto_ack = 1'b1; ack_lat = 2; addr_model = 1'b1;
      wait_count(40, n);
      pop_sample(exp, ok);
      compared++;
      if (n != PER || !ok || exp != 6) begin
         mismatched++;
         $display("FAIL under_setup: count at %0d sample=%0d required %0d and 6", n, exp, PER);
      end
      auto_ack = 1'b0;
      run_period(6, 0, '0, high, perr, sk);
      compared++;
      if (sk != PER || underrun !== 1'b1 || count !== 1'b0) begin
         mismatched++;
         $display("FAIL under_strobe: strobe at %0d underrun=%b count=%b required 1 0 at %0d", sk, underrun, count, PER);
      end
      auto_ack = 1'b1;
      run_period(6, 0, '0, high, perr, sk);
      compared++;
      if (high != 6 || perr != 0) begin
         mismatched++;
         $display("FAIL under_repeat: high=%0d err=%0d required 6 0", high, perr);
      end
      compared++;
      if (sk != PER || count !== 1'b1) begin
         mismatched++;
         $display("FAIL under_recover: strobe at %0d count=%b required count at %0d", sk, count, PER);
      end
      pop_sample(exp, ok);
      run_period(exp, 0, '0, high, perr, sk);
      compared++;
      if (!ok || high != 10 || perr != 0 || n_under != 1) begin
         mismatched++;
         $display("FAIL under_late: high=%0d err=%0d underruns=%0d required 10 0 1", high, perr, n_under);
      end
   endtask

   task automatic test_bypass();
      int n, exp, high, perr, sk;
      bit ok;
      apply_reset(ADDR_W'(30));
      play = 1'b1; auto_ack = 1'b1; ack_lat = 2; addr_model = 1'b1;
      wait_count(40, n);
      pop_sample(exp, ok);
      auto_ack = 1'b0;
      run_period(exp, PER - 1, 4'd9, high, perr, sk);
      compared++;
      if (sk != PER || count !== 1'b1 || underrun !== 1'b0) begin
         mismatched++;
         $display("FAIL bypass_count: strobe at %0d count=%b underrun=%b required 1 0 at %0d", sk, count, underrun, PER);
      end
      auto_ack = 1'b1;
      pop_sample(exp, ok);
      run_period(9, 0, '0, high, perr, sk);
      compared++;
      if (!ok || exp != 9 || high != 9 || perr != 0) begin
         mismatched++;
         $display("FAIL bypass_duty: sample=%0d high=%0d err=%0d required 9 9 0", exp, high, perr);
      end
      compared++;
      if (sk != PER || count !== 1'b1 || n_under != 0) begin
         mismatched++;
         $display("FAIL bypass_next: strobe at %0d count=%b under=%0d required count at %0d, 0", sk, count, n_under, PER);
      end
   endtask

   task automatic test_play_drop();
      int n, exp, high, perr, sk, hi, st;
      bit ok;
      apply_reset(ADDR_W'(40));
      play = 1'b1; auto_ack = 1'b1; ack_lat = 2; addr_model = 1'b1;
      wait_count(40, n);
      pop_sample(exp, ok);
      auto_ack = 1'b0;
      repeat (3) cyc();
      compared++;
      if (mem_req !== 1'b1 || pwm_out !== 1'b1) begin
         mismatched++;
         $display("FAIL drop_pre: mem_req=%b pwm_out=%b required 1 1", mem_req, pwm_out);
      end
      play = 1'b0;
      cyc();
      compared++;
      if (pwm_out !== 1'b0 || mem_req !== 1'b1) begin
         mismatched++;
         $display("FAIL drop_pwm: pwm_out=%b mem_req=%b required 0 1", pwm_out, mem_req);
      end
      auto_ack = 1'b1; ack_lat = 1;
      hi = 0; st = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (pwm_out !== 1'b0) hi++;
         if (count !== 1'b0 || underrun !== 1'b0) st++;
      end
      compared++;
      if (hi != 0 || st != 0 || mem_req !== 1'b0) begin
         mismatched++;
         $display("FAIL drop_idle: pwm_high=%0d strobes=%0d mem_req=%b required 0 0 0", hi, st, mem_req);
      end
      auto_ack = 1'b0;
      mem_ack = 1'b1; mem_data = 4'd7;
      repeat (3) cyc();
      play = 1'b1; auto_ack = 1'b1; ack_lat = 2;
      run_period(5, 0, '0, high, perr, sk);
      compared++;
      if (high != 5 || perr != 0 || sk != PER || count !== 1'b1) begin
         mismatched++;
         $display("FAIL drop_resume: high=%0d err=%0d strobe at %0d required 5 0 count at %0d", high, perr, sk, PER);
      end
      pop_sample(exp, ok);
      run_period(exp, 0, '0, high, perr, sk);
      compared++;
      if (!ok || exp != 12 || high != 12 || perr != 0 || n_under != 0) begin
         mismatched++;
         $display("FAIL drop_buffered: sample=%0d high=%0d err=%0d under=%0d required 12 12 0 0", exp, high, perr, n_under);
      end
   endtask

   initial begin
      reset = 1'b1; play = 1'b0; endereco = '0; mem_ack = 1'b0; mem_data = '0;
      for (int i = 0; i < 64; i++) mem_img[i] = DATA_W'(i * 5 + 3);
      mem_img[5]  = 4'd4;  mem_img[6]  = 4'd11; mem_img[7]  = 4'd0;
      mem_img[8]  = 4'd15; mem_img[9]  = 4'd7;
      mem_img[20] = 4'd6;  mem_img[21] = 4'd10; mem_img[22] = 4'd3;
      mem_img[30] = 4'd3;  mem_img[31] = 4'd1;  mem_img[32] = 4'd5;
      mem_img[40] = 4'd5;  mem_img[41] = 4'd12; mem_img[42] = 4'd2;
      test_reset();
      test_steady();
      test_underrun();
      test_bypass();
      test_play_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/leitor_amostras_pwm.md
Name: leitor_amostras_pwm

Overview:
- Downstream consumer of the current-address ASM (`endereco`, 22 bits).
- Fetches one audio sample per PWM period from external sample memory at the current address, double-buffers it, and drives a PWM audio output.
- Issues a one-cycle `count` strobe at each sample boundary. That strobe is what advances the address ASM.

Parameters:
ADDR_W, 22, width of endereco / mem_addr
DATA_W, 8, sample width; PWM period = 2^DATA_W clock cycles, one sample per period

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
play  input  1  playback enable level
endereco  input  ADDR_W  current sample address from the address ASM
mem_req  output  1  memory read request, held until mem_ack
mem_addr  output  ADDR_W  read address, stable while mem_req=1
mem_ack  input  1  one-cycle read acknowledge; mem_data valid in same cycle
mem_data  input  DATA_W  read data
count  output  1  one-cycle strobe: sample consumed, advance address
pwm_out  output  1  registered PWM audio output
underrun  output  1  one-cycle strobe: boundary reached with no sample ready

Behaviour:
- Reset (sync, reset=1 at edge) clears all state, overriding every other input:
  - pwm_cnt=0, duty=0, buffer=0, buf_valid=0, state=OCIOSO.
  - Outputs: mem_req=0, mem_addr=0, count=0, pwm_out=0, underrun=0.
  - Any outstanding request is abandoned; a mem_ack arriving after reset is ignored.
- pwm_cnt (DATA_W bits):
  - Increments each cycle while play=1 and wraps 2^DATA_W-1 -> 0.
  - play=0 forces pwm_cnt to 0 on the next edge.
- pwm_out is registered: pwm_out <= play & (pwm_cnt < duty), giving one cycle of latency.
  - duty=0 gives constant 0.
  - duty=2^DATA_W-1 gives high for 2^DATA_W-1 of 2^DATA_W cycles.
- Wrap cycle = a cycle with play=1 and pwm_cnt=2^DATA_W-1. At the edge ending it:
  - buf_valid=1: duty <= buffer, buf_valid <= 0, count=1 for exactly one cycle.
  - buf_valid=0 and mem_ack=1 in the same cycle (bypass): duty <= mem_data, count=1, buffer untouched, buf_valid stays 0.
  - Otherwise: duty unchanged (previous sample repeats), underrun=1 for one cycle, count=0.
- count and underrun are never both 1. Neither is asserted while play=0.
- Fetch FSM:
  - OCIOSO: if play=1, buf_valid=0 and count=0 this cycle -> mem_addr <= endereco, mem_req <= 1, go to PEDE.
    - The count=0 condition gives the address ASM one cycle to update endereco after a count strobe.
  - PEDE: mem_req=1 and mem_addr held.
    - On mem_ack=1, go to CHEIO, unless this is the wrap-cycle bypass case, in which case go to OCIOSO.
    - The edge that sees mem_ack clears mem_req.
    - mem_req stays high regardless of play; a request started before play falls is completed and buffered.
  - CHEIO: buf_valid=1. At the wrap transfer go to OCIOSO.
  - mem_ack while mem_req=0 is ignored.
- play 1->0 mid-period:
  - pwm_cnt -> 0 and pwm_out -> 0 next cycle.
  - duty and buffer are retained; no count is issued.
  - On play 0->1, the period restarts from pwm_cnt=0 with the retained duty.
- Steady state: one count per 2^DATA_W cycles, and the address advances exactly once per sample.

Test Plan (DATA_W=4, period 16):
- Reset high 3 cycles -> all outputs 0. Release with play=1, endereco=5 -> mem_req=1, mem_addr=5 two cycles later. Reset mid-PEDE -> mem_req=0 next cycle.
- play=1, memory acks after 2 cycles with data 4 -> at first wrap count=1 for 1 cycle, duty=4. Next period pwm_out high for exactly 4 of 16 cycles, delayed one cycle.
- Address ASM model increments endereco on count -> successive mem_addr 5, 6, 7. Exactly one count per 16 cycles and no underrun.
- Memory withholds ack through a wrap -> underrun=1 for 1 cycle, count=0, pwm duty repeats the old value. Late ack then loads buffer, and the next wrap gives count=1.
- mem_ack with data 9 arriving exactly in the wrap cycle while buf_valid=0 -> count=1, duty=9 next period, no underrun.
- Drop play mid-period with a request pending -> pwm_out=0 next cycle, request completes with ack, no count. Re-assert play -> count occurs 16 cycles later with the buffered sample. Stray mem_ack while idle leaves state unchanged.
